// File: rtl/axi_crossbar_addr_admit.sv
// axi_crossbar_addr_admit: address decode and admission for one crossbar slave port.
// Ports: clk/rst (sync, active-high); s_axi_a* request in; m_axi_a* issue out;
// m_wc_* write command out; m_rc_* decode-error response command out;
// s_cpl_* transaction completion in.
module axi_crossbar_addr_admit #(
    parameter int S          = 0,
    parameter int S_COUNT    = 4,
    parameter int M_COUNT    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int S_THREADS  = 2,
    parameter int S_ACCEPT   = 16,
    parameter int M_REGIONS  = 1,
    parameter logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
    parameter logic [M_COUNT*M_REGIONS*32-1:0] M_ADDR_WIDTH =
        {M_COUNT{{M_REGIONS{32'd24}}}},
    parameter logic [M_COUNT*S_COUNT-1:0] M_CONNECT = '1,
    parameter logic [M_COUNT-1:0]         M_SECURE  = '0,
    parameter logic [M_COUNT*8-1:0]       M_ISSUE   = {M_COUNT{8'd8}},
    parameter bit                         WC_OUTPUT = 1'b0,
    localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_aid,
    input  logic [ADDR_WIDTH-1:0] s_axi_aaddr,
    input  logic [2:0]            s_axi_aprot,
    input  logic                  s_axi_avalid,
    output logic                  s_axi_aready,
    output logic [3:0]            m_axi_aregion,
    output logic [SEL_W-1:0]      m_select,
    output logic                  m_axi_avalid,
    input  logic                  m_axi_aready,
    output logic [SEL_W-1:0]      m_wc_select,
    output logic                  m_wc_decerr,
    output logic                  m_wc_valid,
    input  logic                  m_wc_ready,
    output logic                  m_rc_decerr,
    output logic                  m_rc_valid,
    input  logic                  m_rc_ready,
    input  logic [ID_WIDTH-1:0]   s_cpl_id,
    input  logic                  s_cpl_valid
);

    localparam int TH    = (S_THREADS < S_ACCEPT) ? S_THREADS : S_ACCEPT;
    localparam int TH_W  = (TH > 1) ? $clog2(TH) : 1;
    localparam int CNT_W = $clog2(S_ACCEPT + 1);
    localparam logic [CNT_W-1:0] ACC_MAX = CNT_W'(S_ACCEPT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_avalid, w_avalid_nxt;
    logic             r_wc_valid, w_wc_valid_nxt;
    logic             r_rc_valid, w_rc_valid_nxt;
    logic             r_decerr, w_decerr_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [3:0]       r_region, w_region_nxt;

    logic [CNT_W-1:0]    r_total;
    logic [CNT_W-1:0]    r_th_cnt    [TH];
    logic [ID_WIDTH-1:0] r_th_id     [TH];
    logic [SEL_W-1:0]    r_th_sel    [TH];
    logic [3:0]          r_th_region [TH];
    logic                r_th_decerr [TH];
    logic [7:0]          r_m_cnt     [M_COUNT];

    logic             w_dec_hit, w_decerr;
    logic [SEL_W-1:0] w_dec_sel;
    logic [3:0]       w_dec_region;
    logic             w_hit, w_free, w_cpl_hit;
    logic [TH_W-1:0]  w_hit_idx, w_free_idx, w_cpl_idx, w_acc_idx;
    logic [7:0]       w_lim, w_mcnt;
    logic             w_same_dest, w_cpl_master;
    logic [SEL_W-1:0] w_cpl_sel;
    logic             w_thread_ok, w_total_ok, w_master_ok, w_admit;
    logic             w_drain, w_accept;
    logic [TH-1:0]      w_th_inc, w_th_dec;
    logic [M_COUNT-1:0] w_m_inc, w_m_dec;
    logic               w_unused_prot;

    assign w_unused_prot = ^{s_axi_aprot[2], s_axi_aprot[0]};

    function automatic logic region_match(
        input int                    idx,
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [31:0]           wd;
        logic [ADDR_WIDTH-1:0] base;
        wd   = M_ADDR_WIDTH[idx*32 +: 32];
        base = M_BASE_ADDR[idx*ADDR_WIDTH +: ADDR_WIDTH];
        return (wd != 32'd0) && ((addr >> wd) == (base >> wd));
    endfunction

    // Ascending scan with overwrite: the highest matching region wins.
    always_comb begin
        w_dec_hit    = 1'b0;
        w_dec_sel    = '0;
        w_dec_region = '0;
        for (int m = 0; m < M_COUNT; m++) begin
            for (int r = 0; r < M_REGIONS; r++) begin
                if (M_CONNECT[m*S_COUNT+S] &&
                    !(M_SECURE[m] && s_axi_aprot[1]) &&
                    region_match(m*M_REGIONS+r, s_axi_aaddr)) begin
                    w_dec_hit    = 1'b1;
                    w_dec_sel    = SEL_W'(m);
                    w_dec_region = 4'(r);
                end
            end
        end
    end

    assign w_decerr = !w_dec_hit;

    // Descending scan so the lowest free thread is chosen.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_cpl_hit  = 1'b0;
        w_cpl_idx  = '0;
        for (int t = TH - 1; t >= 0; t--) begin
            if (r_th_cnt[t] == '0) begin
                w_free     = 1'b1;
                w_free_idx = TH_W'(t);
            end else begin
                if (r_th_id[t] == s_axi_aid) begin
                    w_hit     = 1'b1;
                    w_hit_idx = TH_W'(t);
                end
                if (s_cpl_valid && (r_th_id[t] == s_cpl_id)) begin
                    w_cpl_hit = 1'b1;
                    w_cpl_idx = TH_W'(t);
                end
            end
        end
    end

    always_comb begin
        w_lim  = '0;
        w_mcnt = '0;
        for (int m = 0; m < M_COUNT; m++) begin
            if (w_dec_sel == SEL_W'(m)) begin
                w_lim  = M_ISSUE[m*8 +: 8];
                w_mcnt = r_m_cnt[m];
            end
        end
    end

    assign w_same_dest = (r_th_sel[w_hit_idx] == w_dec_sel) &&
                         (r_th_region[w_hit_idx] == w_dec_region) &&
                         (r_th_decerr[w_hit_idx] == w_decerr);
    assign w_cpl_master = w_cpl_hit && !r_th_decerr[w_cpl_idx];
    assign w_cpl_sel    = r_th_sel[w_cpl_idx];

    // A same-ID request must follow its active thread's destination,
    // decode errors included, so responses stay in ID order.
    assign w_thread_ok = w_hit ? w_same_dest : w_free;
    assign w_total_ok  = (r_total < ACC_MAX) || w_cpl_hit;
    assign w_master_ok = w_decerr || (w_lim == 8'd0) || (w_mcnt < w_lim) ||
                         (w_cpl_master && (w_cpl_sel == w_dec_sel));
    assign w_admit     = w_thread_ok && w_total_ok && w_master_ok;

    assign w_drain  = (!r_avalid || m_axi_aready) &&
                      (!r_wc_valid || m_wc_ready) &&
                      (!r_rc_valid || m_rc_ready);
    assign w_accept = !rst && s_axi_avalid && w_admit &&
                      ((r_state == ST_IDLE) || w_drain);
    assign w_acc_idx = w_hit ? w_hit_idx : w_free_idx;

    assign s_axi_aready  = w_accept;
    assign m_axi_avalid  = r_avalid;
    assign m_axi_aregion = r_region;
    assign m_select      = r_sel;
    assign m_wc_select   = r_sel;
    assign m_wc_decerr   = r_decerr;
    assign m_wc_valid    = r_wc_valid;
    assign m_rc_decerr   = r_decerr;
    assign m_rc_valid    = r_rc_valid;

    always_comb begin
        w_state_nxt    = r_state;
        w_avalid_nxt   = r_avalid && !m_axi_aready;
        w_wc_valid_nxt = r_wc_valid && !m_wc_ready;
        w_rc_valid_nxt = r_rc_valid && !m_rc_ready;
        w_sel_nxt      = r_sel;
        w_region_nxt   = r_region;
        w_decerr_nxt   = r_decerr;
        if (w_accept) begin
            w_avalid_nxt   = !w_decerr;
            w_wc_valid_nxt = WC_OUTPUT;
            w_rc_valid_nxt = w_decerr;
            w_sel_nxt      = w_dec_sel;
            w_region_nxt   = w_dec_region;
            w_decerr_nxt   = w_decerr;
        end
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!w_accept && !w_avalid_nxt &&
                    !w_wc_valid_nxt && !w_rc_valid_nxt)
                    w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_avalid   <= 1'b0;
            r_wc_valid <= 1'b0;
            r_rc_valid <= 1'b0;
            r_decerr   <= 1'b0;
            r_sel      <= '0;
            r_region   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_avalid   <= w_avalid_nxt;
            r_wc_valid <= w_wc_valid_nxt;
            r_rc_valid <= w_rc_valid_nxt;
            r_decerr   <= w_decerr_nxt;
            r_sel      <= w_sel_nxt;
            r_region   <= w_region_nxt;
        end
    end

    always_comb begin
        w_th_inc = '0;
        w_th_dec = '0;
        w_m_inc  = '0;
        w_m_dec  = '0;
        for (int t = 0; t < TH; t++) begin
            w_th_inc[t] = w_accept && (w_acc_idx == TH_W'(t));
            w_th_dec[t] = w_cpl_hit && (w_cpl_idx == TH_W'(t));
        end
        for (int m = 0; m < M_COUNT; m++) begin
            w_m_inc[m] = w_accept && !w_decerr &&
                         (w_dec_sel == SEL_W'(m));
            w_m_dec[m] = w_cpl_master && (w_cpl_sel == SEL_W'(m));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= '0;
            for (int t = 0; t < TH; t++) begin
                r_th_cnt[t]    <= '0;
                r_th_id[t]     <= '0;
                r_th_sel[t]    <= '0;
                r_th_region[t] <= '0;
                r_th_decerr[t] <= 1'b0;
            end
            for (int m = 0; m < M_COUNT; m++) begin
                r_m_cnt[m] <= '0;
            end
        end else begin
            if (w_accept && !w_cpl_hit)
                r_total <= r_total + CNT_ONE;
            else if (!w_accept && w_cpl_hit)
                r_total <= r_total - CNT_ONE;
            for (int t = 0; t < TH; t++) begin
                if (w_th_inc[t]) begin
                    r_th_id[t]     <= s_axi_aid;
                    r_th_sel[t]    <= w_dec_sel;
                    r_th_region[t] <= w_dec_region;
                    r_th_decerr[t] <= w_decerr;
                end
                if (w_th_inc[t] && !w_th_dec[t])
                    r_th_cnt[t] <= r_th_cnt[t] + CNT_ONE;
                else if (!w_th_inc[t] && w_th_dec[t])
                    r_th_cnt[t] <= r_th_cnt[t] - CNT_ONE;
            end
            for (int m = 0; m < M_COUNT; m++) begin
                if (w_m_inc[m] && !w_m_dec[m])
                    r_m_cnt[m] <= r_m_cnt[m] + 8'd1;
                else if (!w_m_inc[m] && w_m_dec[m])
                    r_m_cnt[m] <= r_m_cnt[m] - 8'd1;
            end
        end
    end

endmodule
